// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and decode for the display driver and its monitor.
// Segment order is {a,b,c,d,e,f,g}, active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b1100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {StUnlocked, StLocked} state_e;

  // Returns {legal, blank, digit[3:0]}; an illegal code has both flags low.
  function automatic logic [5:0] seg7_decode(input logic [6:0] pattern);
    logic [5:0] res;
    res = 6'b00_0000;
    case (pattern)
      SEG_0:     res = 6'b10_0000;
      SEG_1:     res = 6'b10_0001;
      SEG_2:     res = 6'b10_0010;
      SEG_3:     res = 6'b10_0011;
      SEG_4:     res = 6'b10_0100;
      SEG_5:     res = 6'b10_0101;
      SEG_6:     res = 6'b10_0110;
      SEG_7:     res = 6'b10_0111;
      SEG_8:     res = 6'b10_1000;
      SEG_9:     res = 6'b10_1001;
      SEG_BLANK: res = 6'b01_0000;
      default:   res = 6'b00_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Input register plus stability counter; strobes accept once per stable run of
// STABLE_CYCLES samples.
module seg7_stable_filter
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_n,
  output logic       accept,
  output logic [6:0] pattern
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ACC = CW'(STABLE_CYCLES - 1);

  logic [6:0]    seg_s;
  logic [CW-1:0] cnt;

  // The counter describes the value being loaded into seg_s, so it restarts
  // in the same edge that a new value is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s <= SEG_BLANK;
      cnt   <= '0;
    end else begin
      seg_s <= seg_n;
      if (seg_n != seg_s) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign accept  = (cnt == CNT_ACC);
  assign pattern = seg_s;

endmodule

// File: rtl/seg7_digit_monitor.sv
// Receive-side checker for the 7-segment digit counter: filters, decodes and
// verifies that accepted digits increment modulo 10.
module seg7_digit_monitor
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_n,
  output logic       digit_valid,
  output logic [3:0] digit,
  output logic       is_blank,
  output logic       illegal,
  output logic       seq_error,
  output logic       locked,
  output logic [7:0] err_count
);

  logic       accept;
  logic [6:0] pattern;
  logic [6:0] last_pat;
  logic [5:0] dec;
  logic       dec_legal;
  logic       dec_blank;
  logic [3:0] dec_digit;
  logic       new_evt;
  logic [3:0] next_digit;
  logic [7:0] err_sat;
  state_e     state;

  seg7_stable_filter #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk     (clk),
    .rst     (rst),
    .seg_n   (seg_n),
    .accept  (accept),
    .pattern (pattern)
  );

  always_comb begin
    dec        = seg7_decode(pattern);
    dec_legal  = dec[5];
    dec_blank  = dec[4];
    dec_digit  = dec[3:0];
    new_evt    = accept && (pattern != last_pat);
    next_digit = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    err_sat    = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StUnlocked;
      last_pat    <= SEG_BLANK;
      digit_valid <= 1'b0;
      digit       <= 4'd0;
      is_blank    <= 1'b0;
      illegal     <= 1'b0;
      seq_error   <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      digit_valid <= 1'b0;
      illegal     <= 1'b0;
      seq_error   <= 1'b0;
      if (new_evt) begin
        last_pat <= pattern;
        if (dec_legal) begin
          digit_valid <= 1'b1;
          digit       <= dec_digit;
          is_blank    <= 1'b0;
          state       <= StLocked;
          if (state == StLocked && dec_digit != next_digit) begin
            seq_error <= 1'b1;
            err_count <= err_sat;
          end
        end else if (dec_blank) begin
          is_blank <= 1'b1;
          state    <= StUnlocked;
        end else begin
          illegal   <= 1'b1;
          is_blank  <= 1'b0;
          state     <= StUnlocked;
          err_count <= err_sat;
        end
      end
    end
  end

  assign locked = (state == StLocked);

endmodule

// File: tb/tb_seg7_digit_monitor.sv
// Directed bench for seg7_digit_monitor with STABLE_CYCLES=4.
module tb_seg7_digit_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_n;
  logic       digit_valid;
  logic [3:0] digit;
  logic       is_blank;
  logic       illegal;
  logic       seq_error;
  logic       locked;
  logic [7:0] err_count;

  int vectors = 0;
  int errors  = 0;

  // Pulse tallies gathered by hold()
  int dv_cnt, se_cnt, il_cnt, both_cnt;
  logic [3:0] pulse_digit;

  logic [6:0] seg_tab [0:9];
  localparam logic [6:0] PAT_BLANK   = 7'b1111111;
  localparam logic [6:0] PAT_ILLEGAL = 7'b0101010;

  seg7_digit_monitor #(
    .STABLE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .digit_valid (digit_valid),
    .digit       (digit),
    .is_blank    (is_blank),
    .illegal     (illegal),
    .seq_error   (seq_error),
    .locked      (locked),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [6:0] pat, input int n);
    dv_cnt = 0; se_cnt = 0; il_cnt = 0; both_cnt = 0;
    seg_n = pat;
    for (int i = 0; i < n; i++) begin
      step();
      if (digit_valid) begin
        dv_cnt++;
        pulse_digit = digit;
      end
      if (seq_error) se_cnt++;
      if (illegal) il_cnt++;
      if (digit_valid && seq_error) both_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    seg_n = PAT_BLANK;
    repeat (3) step();
    vectors++;
    if ({digit_valid, digit, is_blank, illegal, seq_error, locked, err_count} !== 17'd0) begin
      $display("FAIL reset_outputs: got %b, want all zero",
               {digit_valid, digit, is_blank, illegal, seq_error, locked, err_count});
      errors++;
    end
    rst = 1'b0;
    hold(PAT_BLANK, 10);
    vectors++;
    if (dv_cnt + il_cnt + se_cnt !== 0 || is_blank !== 1'b0) begin
      $display("FAIL blank_after_reset: pulses=%0d is_blank=%b, want 0/0",
               dv_cnt + il_cnt + se_cnt, is_blank);
      errors++;
    end
  endtask

  task automatic test_count();
    for (int k = 0; k <= 10; k++) begin
      hold(seg_tab[k % 10], 10);
      vectors++;
      if (dv_cnt !== 1 || pulse_digit !== 4'(k % 10) || digit !== 4'(k % 10)) begin
        $display("FAIL count_%0d: pulses=%0d digit=%0d, want 1 pulse digit %0d",
                 k, dv_cnt, digit, k % 10);
        errors++;
      end
      vectors++;
      if (locked !== 1'b1 || se_cnt !== 0 || err_count !== 8'd0) begin
        $display("FAIL count_state_%0d: locked=%b seq_err=%0d err=%0d, want 1/0/0",
                 k, locked, se_cnt, err_count);
        errors++;
      end
    end
  endtask

  task automatic test_latency();
    // Currently showing 0; the pulse for 1 must land on the 5th edge.
    seg_n = seg_tab[1];
    for (int e = 1; e <= 6; e++) begin
      step();
      vectors++;
      if (digit_valid !== (e == 5)) begin
        $display("FAIL latency_edge_%0d: digit_valid=%b, want %b", e, digit_valid, e == 5);
        errors++;
      end
    end
    hold(seg_tab[1], 4);
  endtask

  task automatic test_glitch();
    hold(seg_tab[2], 10);
    hold(seg_tab[3], 10);
    hold(seg_tab[8], 3);
    vectors++;
    if (dv_cnt + il_cnt !== 0) begin
      $display("FAIL glitch_pulse: pulses=%0d, want 0", dv_cnt + il_cnt);
      errors++;
    end
    hold(seg_tab[3], 10);
    vectors++;
    if (dv_cnt + il_cnt + se_cnt !== 0 || digit !== 4'd3) begin
      $display("FAIL glitch_return: pulses=%0d digit=%0d, want 0 and 3",
               dv_cnt + il_cnt + se_cnt, digit);
      errors++;
    end
  endtask

  task automatic test_seq_error();
    hold(PAT_BLANK, 10);
    vectors++;
    if (is_blank !== 1'b1 || locked !== 1'b0) begin
      $display("FAIL blank_unlock: is_blank=%b locked=%b, want 1/0", is_blank, locked);
      errors++;
    end
    hold(seg_tab[2], 10);
    vectors++;
    if (dv_cnt !== 1 || se_cnt !== 0 || locked !== 1'b1 || is_blank !== 1'b0) begin
      $display("FAIL relock_2: dv=%0d se=%0d locked=%b blank=%b, want 1/0/1/0",
               dv_cnt, se_cnt, locked, is_blank);
      errors++;
    end
    hold(seg_tab[4], 10);
    vectors++;
    if (both_cnt !== 1 || dv_cnt !== 1 || digit !== 4'd4 || err_count !== 8'd1 ||
        locked !== 1'b1) begin
      $display("FAIL seq_error: both=%0d dv=%0d digit=%0d err=%0d locked=%b, want 1/1/4/1/1",
               both_cnt, dv_cnt, digit, err_count, locked);
      errors++;
    end
  endtask

  task automatic test_illegal();
    hold(PAT_ILLEGAL, 10);
    vectors++;
    if (il_cnt !== 1 || err_count !== 8'd2 || locked !== 1'b0 || digit !== 4'd4) begin
      $display("FAIL illegal: il=%0d err=%0d locked=%b digit=%0d, want 1/2/0/4",
               il_cnt, err_count, locked, digit);
      errors++;
    end
    hold(seg_tab[7], 10);
    vectors++;
    if (dv_cnt !== 1 || se_cnt !== 0 || locked !== 1'b1 || digit !== 4'd7) begin
      $display("FAIL relock_7: dv=%0d se=%0d locked=%b digit=%0d, want 1/0/1/7",
               dv_cnt, se_cnt, locked, digit);
      errors++;
    end
  endtask

  task automatic test_saturate();
    int il_total;
    int wraps;
    logic [7:0] prev;
    il_total = 0;
    wraps = 0;
    prev = err_count;
    for (int i = 0; i < 300; i++) begin
      hold(PAT_ILLEGAL, 5);
      il_total += il_cnt;
      if (err_count < prev) wraps++;
      prev = err_count;
      hold(seg_tab[1], 5);
      if (err_count < prev) wraps++;
      prev = err_count;
    end
    vectors++;
    if (err_count !== 8'd255 || wraps !== 0 || il_total !== 300) begin
      $display("FAIL saturate: err=%0d wraps=%0d illegal=%0d, want 255/0/300",
               err_count, wraps, il_total);
      errors++;
    end
  endtask

  task automatic test_reset_mid();
    int hit;
    hold(seg_tab[2], 2);
    rst = 1'b1;
    step();
    vectors++;
    if ({digit_valid, digit, is_blank, illegal, seq_error, locked, err_count} !== 17'd0) begin
      $display("FAIL reset_mid: got %b, want all zero",
               {digit_valid, digit, is_blank, illegal, seq_error, locked, err_count});
      errors++;
    end
    rst = 1'b0;
    hit = 0;
    for (int e = 1; e <= 8 && hit == 0; e++) begin
      step();
      if (digit_valid) hit = e;
    end
    vectors++;
    if (hit !== 5 || digit !== 4'd2 || locked !== 1'b1 || err_count !== 8'd0) begin
      $display("FAIL reset_resume: edge=%0d digit=%0d locked=%b err=%0d, want 5/2/1/0",
               hit, digit, locked, err_count);
      errors++;
    end
    hold(seg_tab[2], 50);
    vectors++;
    if (dv_cnt + il_cnt + se_cnt !== 0) begin
      $display("FAIL hold_forever: pulses=%0d, want 0", dv_cnt + il_cnt + se_cnt);
      errors++;
    end
  endtask

  initial begin
    seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
    seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
    seg_tab[6] = 7'b1100000; seg_tab[7] = 7'b0001111; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0001100;
    pulse_digit = 4'd0;
    test_reset();
    test_count();
    test_latency();
    test_glitch();
    test_seq_error();
    test_illegal();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
